sr_latch_driver: RTL
====================

# sr_latch_driver

Clocked command-side controller for the level-sensitive SR latch cells. It accepts set/reset/hold commands over a valid/ready handshake and sequences the latch's `s`, `r` and `en` lines with guaranteed setup and hold around the enable pulse. It never drives `s=r=1`. After each write it reads back `q` through a synchronizer and reports a mismatch. It sits between synchronous control logic and any latch-based storage or control element.

## Interface
Parameters:
- `SETUP_CYC`, default 1: cycles that `s`/`r` are stable with `en=0` before the enable pulse. Minimum 1.
- `PULSE_CYC`, default 2: cycles that `en=1`. Minimum 1.
- `HOLD_CYC`, default 1: cycles that `s`/`r` stay stable with `en=0` after the pulse. Minimum 1.
- `SYNC_STAGES`, default 2: flops in the `q_in` readback synchronizer. Minimum 2.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command present.
- `cmd_op`, input, 2: command code. 00 = hold, 01 = reset, 10 = set, 11 = illegal.
- `cmd_ready`, output, 1: high only in IDLE.
- `s`, output, 1: latch set line (registered).
- `r`, output, 1: latch reset line (registered).
- `en`, output, 1: latch enable (registered).
- `q_in`, input, 1: latch Q, asynchronous to `clk`.
- `q_sync`, output, 1: synchronized copy of `q_in`.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: one-cycle error pulse. Only ever asserted together with `done`.

## Operation
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK, DONE. One down-counter is reloaded on each state entry.
- IDLE:
  - `cmd_ready=1`; `s=r=en=0`.
  - op 01 or 10: go to SETUP. Latch expected value `exp = cmd_op[1]`.
  - op 00: go to DONE with `err=0`. Latch lines untouched.
  - op 11: go to DONE with `err=1`. Latch lines untouched.
- SETUP (SETUP_CYC cycles): `s = exp`, `r = ~exp`, `en=0`.
- PULSE (PULSE_CYC cycles): `s`/`r` unchanged, `en=1`.
- HOLD (HOLD_CYC cycles): `en=0`, `s`/`r` unchanged. On exit, `s` and `r` return to 0.
- CHECK (SYNC_STAGES cycles): `s=r=en=0`. Lets the readback propagate through the synchronizer.
- DONE (1 cycle):
  - `done=1`.
  - For set/reset, `err = (q_sync != exp)`.
  - Always returns to IDLE.
- Invariants, which are assertion targets:
  - `s&r` is never 1.
  - `s` and `r` change only while `en=0`.
  - `en` is only 1 in PULSE.
- The synchronizer runs continuously, independent of the FSM. `q_sync` reflects `q_in` after SYNC_STAGES edges.
- `cmd_op` is sampled only at acceptance. Later changes to it are ignored.

## Timing
- Reset (asynchronous assert, synchronous-free release):
  - Outputs: `s=r=en=0`, `done=err=0`, `busy=0`, `cmd_ready=1`.
  - Internal: state IDLE, synchronizer flops 0, so `q_sync=0`.
- Reset mid-sequence: `en` and `s`/`r` drop immediately on `rst_n` fall. The latch keeps whatever it captured. No `done` is produced for the aborted command.
- Latency, with cycle 0 being the first cycle after the acceptance edge:
  - Set/reset: `done` in cycle `SETUP_CYC+PULSE_CYC+HOLD_CYC+SYNC_STAGES`, which is 6 with defaults. `cmd_ready` returns the following cycle.
  - Hold or illegal: `done` in cycle 0. `cmd_ready=1` in cycle 1.
- Throughput: with `cmd_valid` held high, back-to-back accepts occur every 8 cycles (set/reset, defaults) or every 2 cycles (hold/illegal).
- `cmd_ready` is a decode of state==IDLE. `cmd_valid` may be asserted in any cycle. No combinational path runs from `cmd_valid` to `cmd_ready`.

## Test plan
- **Reset values:** Assert `rst_n=0` mid-PULSE of a set. Required: `en`, `s`, `r` all fall to 0 within the same cycle, before the next edge. After release: `cmd_ready=1`, `busy=0`, no `done`.
- **Set:** Issue op 10 with the model latch starting at q=0. Required:
  - `s=1`, `r=0` in cycles 0–3.
  - `en=1` in cycles 1–2 only.
  - `done=1`, `err=0` in cycle 6.
  - `q_sync=1`.
- **Reset:** Issue op 01 after the set. Required: `r=1` in cycles 0–3, `en` in cycles 1–2, `done` in cycle 6 with `err=0`, `q_sync=0`.
- **Fault:** Issue op 10 with the model latch stuck at 0. Required: `done=1`, `err=1` in cycle 6.
- **Hold and illegal:** Issue op 00, then op 11. Required:
  - `done` in cycle 0 both times.
  - `err` is 0 for op 00 and 1 for op 11.
  - `s`, `r`, `en` stay 0 throughout.
- **Back-to-back:** Hold `cmd_valid=1` with ops 10, 01, 10. Required:
  - Accepts 8 cycles apart.
  - `s&r` never 1.
  - `s`/`r` never toggle while `en=1`.
- **Parameter sweep:** Repeat the back-to-back scenario with `SETUP_CYC=3`, `PULSE_CYC=1`, `HOLD_CYC=2`. Required: `done` in cycle 8.

Source files
------------

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Clocked command-side controller for a level-sensitive SR latch cell.
// It accepts hold/reset/set commands over a valid/ready handshake. For a
// write it walks SETUP -> PULSE -> HOLD with the latch s/r lines stable
// around the enable pulse. It then waits in CHECK while the latch output
// propagates through the readback synchronizer. Finally it reports
// completion, and any readback mismatch, in DONE.
//
// Ports
//   clk        : single clock; all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command present
//   cmd_op     : 00 hold, 01 reset, 10 set, 11 illegal (sampled on accept)
//   cmd_ready  : high only in IDLE
//   s, r, en   : registered latch set / reset / enable lines
//   q_in       : latch Q, asynchronous to clk
//   q_sync     : synchronized copy of q_in
//   busy       : high in any state other than IDLE
//   done       : one-cycle completion pulse
//   err        : one-cycle error pulse, only ever together with done
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 2,
    parameter int HOLD_CYC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    output logic       en,
    input  logic       q_in,
    output logic       q_sync,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_CHECK,
        ST_DONE
    } state_e;

    // The down-counter holds "cycles left in this state minus one", so it
    // has to reach the largest phase length minus one.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HK  = (HOLD_CYC > SYNC_STAGES) ? HOLD_CYC : SYNC_STAGES;
    localparam int MAX_CYC = (MAX_SP > MAX_HK) ? MAX_SP : MAX_HK;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_LOAD = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t PULSE_LOAD = cnt_t'(PULSE_CYC - 1);
    localparam cnt_t HOLD_LOAD  = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t CHECK_LOAD = cnt_t'(SYNC_STAGES - 1);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   exp_q, exp_d;          // value the latch must hold after a write
    logic   write_q, write_d;      // current command is set/reset
    logic   illegal_q, illegal_d;  // current command is op 11
    logic   s_q, s_d;
    logic   r_q, r_d;
    logic   en_q, en_d;
    logic [SYNC_STAGES-1:0] sync_q;

    // -------------------------------------------------------------------------
    // Next-state and registered-output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path through the case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        write_d   = write_q;
        illegal_d = illegal_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        2'b01, 2'b10: begin
                            state_d   = ST_SETUP;
                            cnt_d     = SETUP_LOAD;
                            exp_d     = cmd_op[1];
                            write_d   = 1'b1;
                            illegal_d = 1'b0;
                        end
                        2'b00: begin
                            state_d   = ST_DONE;
                            write_d   = 1'b0;
                            illegal_d = 1'b0;
                        end
                        default: begin
                            state_d   = ST_DONE;
                            write_d   = 1'b0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                    cnt_d   = CHECK_LOAD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_CHECK: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The latch lines are registered from the state being entered, so
        // they are glitch-free and line up exactly with the state that owns
        // them. s and r are mutually exclusive by construction (exp vs ~exp).
        s_d  = 1'b0;
        r_d  = 1'b0;
        en_d = 1'b0;
        if (state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD) begin
            s_d = exp_d;
            r_d = ~exp_d;
        end
        if (state_d == ST_PULSE) begin
            en_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the async reset clears the latch lines immediately, so an aborted
    // write never leaves en high or s/r driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            exp_q     <= 1'b0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            write_q   <= write_d;
            illegal_q <= illegal_d;
            s_q       <= s_d;
            r_q       <= r_d;
            en_q      <= en_d;
        end
    end

    // Free-running readback synchronizer, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q_sync    = sync_q[SYNC_STAGES-1];
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done && (illegal_q || (write_q && (q_sync != exp_q)));
    assign s         = s_q;
    assign r         = r_q;
    assign en        = en_q;

endmodule
